p2s_frame_tx: RTL
=================

Name: p2s_frame_tx

Overview:
Parametrised parallel-to-serial frame transmitter and next-generation serial output stage of the link. Accepts a DATA_W-bit word over a valid/ready handshake and shifts out one bit per bit_tick strobe: start bit (0), data bits, optional parity bit, then STOP_BITS stop bits (1). Sits between the word-producing logic and the external serial pin. bit_tick comes from the shared baud-rate divider.

Parameters:
DATA_W, 8, data bits per frame (1..16)
STOP_BITS, 1, stop bits per frame (1 or 2)
MSB_FIRST, 1, 1 = data sent MSB first, 0 = LSB first
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd; ignored otherwise

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
bit_tick  input  1  single-cycle strobe, one per bit period
tx_data  input  DATA_W  word to send; sampled only at accept
tx_valid  input  1  producer has a word
tx_ready  output  1  block can accept a word (high only in IDLE)
serial_out  output  1  serial line, idles high
busy  output  1  frame in progress (not IDLE)
tx_done  output  1  one-cycle pulse when the final stop-bit period ends

Behaviour:
- Reset: state=IDLE, serial_out=1, tx_ready=1, busy=0, tx_done=0, shift register and counters cleared. Reset mid-frame aborts the frame; serial_out=1 from the next edge; the word is lost and tx_done does not pulse.
- Clock domain: all state changes occur on posedge clk.
- bit_tick gating: the line advances only on cycles with bit_tick=1. bit_tick is ignored in IDLE.
- Accept:
  - Occurs when tx_valid && tx_ready at an edge.
  - tx_data is latched and the state moves to START_WAIT.
  - tx_ready drops in the following cycle.
- Accept with bit_tick in the same cycle: the word is accepted and that tick is consumed by nothing. The start bit waits for the next tick.
- FSM (each transition happens on a bit_tick cycle):
  - IDLE: exit on accept.
  - START_WAIT -> START: serial_out<=0.
  - START -> DATA: first data bit driven; bit index=0.
  - DATA: drives the next data bit each tick. After DATA_W bits, moves to PARITY (if compiled in), else to STOP with serial_out<=1.
  - PARITY -> STOP: parity bit was driven on entry to PARITY; serial_out<=1 on entry to STOP.
  - STOP: holds 1 for STOP_BITS ticks. On the tick ending the last stop period: ->IDLE, tx_done=1 for one cycle, tx_ready=1.
- Latency: from accept to tx_done is exactly 2+DATA_W+P+STOP_BITS bit_ticks, where P=1 with parity, 0 without.
- Back-to-back frames: tx_ready is high in the cycle after tx_done. A word accepted then starts its start bit on the next tick, so there is no extra idle bit.
- Stability: serial_out changes only on bit_tick cycles or on reset. tx_data and tx_valid changes outside accept have no effect.
- Bit order: MSB_FIRST=1 sends tx_data[DATA_W-1] down to [0]; 0 sends [0] up to [DATA_W-1].
- Width: the bit counter is clog2(DATA_W+1) bits; the stop counter is 1 bit.

Optional Feature:
P2S_PARITY_EN
- Defined: a PARITY state is inserted after DATA. Parity bit = XOR of the latched word, inverted when PARITY_ODD=1. The frame grows by one bit.
- Undefined: no PARITY state or parity logic; PARITY_ODD is unused.

Decomposition:
- Package p2s_pkg:
  - FSM state typedef (IDLE, START_WAIT, START, DATA, PARITY, STOP).
  - Line-level constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
  - Frame-length function frame_bits(DATA_W, STOP_BITS, P).
- One sub-module p2s_frame_shifter: load/shift register with MSB_FIRST-selected output bit and parity computation. The FSM stays in the top.

Test Plan:
- DATA_W=8, MSB_FIRST=1, tx_data=8'hB5, one tick every 4 clk: serial_out per tick = 0,1,0,1,1,0,1,0,1,1,1. tx_done pulses on tick 11.
- Same with MSB_FIRST=0: line = 0,1,0,1,0,1,1,0,1 then stop 1. busy high from accept to tx_done.
- P2S_PARITY_EN, tx_data=8'hB5:
  - PARITY_ODD=0: parity bit=1 after the data bits.
  - PARITY_ODD=1: parity bit=0.
  - STOP_BITS=2: two 1s before tx_done. Total 13 ticks.
- tx_valid asserted in the same cycle as bit_tick in IDLE: word accepted, start bit appears on the next tick, not the current one. Two words sent back-to-back with no extra idle bit between frames.
- Reset asserted after the 4th data bit: serial_out=1 next cycle, tx_ready=1, busy=0, no tx_done. A new word 8'h3C then transmits correctly.
- tx_valid held high with changing tx_data mid-frame: tx_ready stays 0 and the frame bits are unaffected. The next word is accepted only in the cycle after tx_done.

Source files
------------

// File: rtl/p2s_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : p2s_pkg
// Brief   : Shared types, line levels and frame-length helper for the
//           parallel-to-serial frame transmitter.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package p2s_pkg;

  // Transmitter FSM states; PARITY is only reachable when parity is built in.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_WAIT = 3'd1,
    START      = 3'd2,
    DATA       = 3'd3,
    PARITY     = 3'd4,
    STOP       = 3'd5
  } state_t;

  // Line levels seen on the serial pin.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Number of bit_tick strobes from accept to tx_done.
  function automatic int frame_bits(input int data_w, input int stop_bits, input int p);
    return 2 + data_w + p + stop_bits;
  endfunction

endpackage : p2s_pkg
`default_nettype wire

// File: rtl/p2s_frame_shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : p2s_frame_shifter
// Brief   : Load/shift register presenting the next data bit in the chosen
//           bit order, plus the parity of the word captured at load.
//           Parity logic exists only when P2S_PARITY_EN is defined.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module p2s_frame_shifter #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              bit_o,
  output logic              parity_o
);

  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;

  // Next value of the shift register: load wins, otherwise move toward the output end.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
    end
  end

  // Shift register storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_o = (MSB_FIRST != 0) ? sr_q[DATA_W-1] : sr_q[0];

`ifdef P2S_PARITY_EN
  logic par_q;

  // Parity is taken from the whole word at load, before shifting destroys it.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (load_i) begin
      par_q <= (^data_i) ^ (PARITY_ODD != 0);
    end
  end

  assign parity_o = par_q;
`else
  wire w_unused_parity_odd = (PARITY_ODD != 0);
  assign parity_o = 1'b0;
`endif

endmodule : p2s_frame_shifter
`default_nettype wire

// File: rtl/p2s_frame_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : p2s_frame_tx
// Brief   : Parallel-to-serial frame transmitter. Sends start bit, DATA_W
//           data bits, optional parity bit and STOP_BITS stop bits, one bit
//           per bit_tick strobe. Optional parity: define P2S_PARITY_EN.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module p2s_frame_tx
  import p2s_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_tick,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              tx_done
);

  localparam int              CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DATA_W - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_q, stop_d;
  logic             serial_q, serial_d;
  logic             w_load;
  logic             w_shift;
  logic             w_done;
  logic             w_bit;

`ifdef P2S_PARITY_EN
  logic w_parity;
`else
  logic w_unused_parity;
`endif

  p2s_frame_shifter #(
    .DATA_W     (DATA_W),
    .MSB_FIRST  (MSB_FIRST),
    .PARITY_ODD (PARITY_ODD)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load_i   (w_load),
    .shift_i  (w_shift),
    .data_i   (tx_data),
    .bit_o    (w_bit),
`ifdef P2S_PARITY_EN
    .parity_o (w_parity)
`else
    .parity_o (w_unused_parity)
`endif
  );

  // Next-state, line level and strobes; every transition after accept waits for bit_tick.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    serial_d = serial_q;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_done   = 1'b0;
    case (state_q)
      IDLE: begin
        // bit_tick is deliberately ignored here, so a tick coinciding with accept is dropped.
        if (tx_valid) begin
          w_load  = 1'b1;
          state_d = START_WAIT;
        end
      end
      START_WAIT: begin
        if (bit_tick) begin
          serial_d = START_BIT;
          state_d  = START;
        end
      end
      START: begin
        if (bit_tick) begin
          serial_d = w_bit;
          w_shift  = 1'b1;
          cnt_d    = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (cnt_q == LAST_IDX) begin
`ifdef P2S_PARITY_EN
            serial_d = w_parity;
            state_d  = PARITY;
`else
            serial_d = STOP_BIT;
            stop_d   = 1'b0;
            state_d  = STOP;
`endif
          end else begin
            serial_d = w_bit;
            w_shift  = 1'b1;
            cnt_d    = cnt_q + 1'b1;
          end
        end
      end
`ifdef P2S_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          serial_d = STOP_BIT;
          stop_d   = 1'b0;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (stop_q == STOP_LAST) begin
            w_done  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = LINE_IDLE;
      end
    endcase
  end

  // State, counters and the registered serial line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      stop_q   <= 1'b0;
      serial_q <= LINE_IDLE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      serial_q <= serial_d;
    end
  end

  // tx_done marks the tick that ends the last stop bit; a reset in that cycle suppresses it.
  assign tx_done    = w_done & ~reset;
  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign serial_out = serial_q;

endmodule : p2s_frame_tx
`default_nettype wire
